// File: rtl/intr_gen_model.sv
// rtl/intr_gen_model.sv - LFSR-randomised three-channel level interrupt generator
// Each channel waits a random delay, raises irq until acked, then holds off before re-arming.
module intr_gen_model #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          HOLDOFF   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  intr_en,
    input  logic [3:0]  DLY_WMAX,
    input  logic [2:0]  intr_ack,
    output logic [2:0]  irq,
    output logic [15:0] irq_total,
    output logic [2:0]  spurious_ack
);

    localparam logic [15:0] SEED        = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam int          HW          = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam int          HOLD_LAST_I = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_LAST_I);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ASSERT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t        state_q [3];
    state_t        state_d [3];
    logic [3:0]    dly_q   [3];
    logic [3:0]    dly_d   [3];
    logic [HW-1:0] hold_q  [3];
    logic [HW-1:0] hold_d  [3];
    logic [15:0]   lfsr_q;
    logic [1:0]    enter_cnt;
    logic [16:0]   total_sum;

    always_comb begin
        enter_cnt = 2'd0;
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            dly_d[i]   = dly_q[i];
            hold_d[i]  = hold_q[i];
            case (state_q[i])
                IDLE: begin
                    if (intr_en[i]) begin
                        dly_d[i]   = (lfsr_q[4*i +: 4] > DLY_WMAX) ? DLY_WMAX : lfsr_q[4*i +: 4];
                        state_d[i] = DELAY;
                    end
                end
                DELAY: begin
                    // Dropping the enable cancels the pending interrupt before it is ever seen.
                    if (!intr_en[i]) begin
                        state_d[i] = IDLE;
                        dly_d[i]   = 4'd0;
                    end else if (dly_q[i] == 4'd0) begin
                        state_d[i] = ASSERT;
                    end else begin
                        dly_d[i] = dly_q[i] - 4'd1;
                    end
                end
                ASSERT: begin
                    if (intr_ack[i]) begin
                        state_d[i] = (HOLDOFF == 0) ? IDLE : HOLD;
                        hold_d[i]  = '0;
                    end
                end
                HOLD: begin
                    if (hold_q[i] == HOLD_LAST) begin
                        state_d[i] = IDLE;
                        hold_d[i]  = '0;
                    end else begin
                        hold_d[i] = hold_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
            if (state_d[i] == ASSERT && state_q[i] != ASSERT) begin
                enter_cnt = enter_cnt + 2'd1;
            end
        end
        total_sum = {1'b0, irq_total} + {15'b0, enter_cnt};
    end

    always_comb begin
        irq = 3'b000;
        for (int i = 0; i < 3; i++) begin
            irq[i] = (state_q[i] == ASSERT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q       <= SEED;
            irq_total    <= 16'h0000;
            spurious_ack <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= IDLE;
                dly_q[i]   <= 4'd0;
                hold_q[i]  <= '0;
            end
        end else begin
            // Right-shift Galois form; 16'hB400 is the toggle mask for x^16+x^14+x^13+x^11.
            lfsr_q    <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            irq_total <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                dly_q[i]   <= dly_d[i];
                hold_q[i]  <= hold_d[i];
                if (intr_ack[i] && state_q[i] != ASSERT) begin
                    spurious_ack[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/intr_gen_model.md
INTR_GEN_MODEL -- requirements
Module: intr_gen_model

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1, initial LFSR state; a value of 0 SHALL be replaced by 16'hACE1.
REQ-002 SHALL have parameter HOLDOFF, default 2, the number of idle cycles after an ack.
REQ-003 SHALL have port clk  input  1  the only clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port intr_en  input  3  per-channel enable, driven from err_enable_vec[2:0].
REQ-006 SHALL have port DLY_WMAX  input  4  maximum random assertion delay, in cycles.
REQ-007 SHALL have port intr_ack  input  3  per-channel one-cycle ack pulse from the memory-mapped register at 0x8380_0104.
REQ-008 SHALL have port irq  output  3  level interrupts to the core: bit0 software, bit1 timer, bit2 external.
REQ-009 SHALL have port irq_total  output  16  count of irq assertions, all channels.
REQ-010 SHALL have port spurious_ack  output  3  sticky per-channel flag for an ack received while not asserted.

Function
REQ-011 SHALL run a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11) that advances every cycle out of reset.
REQ-012 SHALL give each channel i an independent FSM with states IDLE, DELAY, ASSERT, HOLD.
REQ-013 IDLE: when intr_en[i]=1, SHALL load dly_cnt = min(lfsr[4i+3:4i], DLY_WMAX) and go to DELAY.
REQ-014 DELAY: SHALL go to ASSERT when dly_cnt==0, otherwise decrement dly_cnt; a loaded delay of 0 SHALL give ASSERT on the next cycle.
REQ-015 DELAY: intr_en[i]=0 SHALL return the channel to IDLE with irq[i] never asserted; this takes priority over REQ-014.
REQ-016 ASSERT: irq[i] SHALL be 1 and be a registered state decode, with no combinational path from any input.
REQ-017 ASSERT: irq[i] SHALL stay 1 until intr_ack[i]=1, regardless of intr_en[i] (level semantics).
REQ-018 ASSERT with intr_ack[i]=1: SHALL go to HOLD, so irq[i] reads 0 on the next cycle.
REQ-019 HOLD: SHALL count HOLDOFF cycles, then go to IDLE; HOLD SHALL ignore intr_en.
REQ-020 Minimum gap from ack to the next irq rise SHALL be HOLDOFF+2 cycles (HOLDOFF in HOLD, 1 in IDLE, 1 in DELAY with dly_cnt=0).
REQ-021 intr_ack[i]=1 in any state other than ASSERT SHALL set spurious_ack[i], SHALL clear only by rst, and SHALL NOT change the FSM state.
REQ-022 irq_total SHALL add 1 for each channel entering ASSERT.
REQ-023 irq_total SHALL add 2 or 3 when that many channels enter ASSERT in the same cycle.
REQ-024 irq_total SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-025 DLY_WMAX SHALL be sampled only when the delay is loaded; changes during DELAY SHALL have no effect.
REQ-026 Simultaneous ack on several channels SHALL be handled independently per channel.

Reset
REQ-027 rst=1 SHALL force: all FSMs to IDLE; irq=0; irq_total=0; spurious_ack=0; dly_cnt=0; HOLD counters=0; LFSR=seed.
REQ-028 rst asserted mid-DELAY, mid-ASSERT or mid-HOLD SHALL take effect on the next rising edge and SHALL drop irq in that same cycle.
REQ-029 Channels SHALL leave IDLE only from the first cycle after rst deasserts.

Verification
REQ-030 rst, intr_en=3'b001, DLY_WMAX=0 -> irq[0] rises 2 cycles after enable; intr_ack[0] pulse -> irq[0] falls next cycle, re-rises 4 cycles later (HOLDOFF=2); irq_total=2.
REQ-031 intr_en=3'b111, DLY_WMAX=15, no ack for 100 cycles -> irq=3'b111 within 17 cycles and stays; irq_total=3.
REQ-032 intr_en[1]=1 then 0 while in DELAY (DLY_WMAX=15, seed giving nibble>=2) -> irq[1] never rises; irq_total=0.
REQ-033 intr_ack=3'b100 with channel 2 in IDLE -> spurious_ack=3'b100, sticky until rst; irq unaffected.
REQ-034 rst pulsed while irq=3'b011 -> irq=0, irq_total=0 on the next cycle; the identical delay sequence repeats after release (same seed).
REQ-035 Force irq_total to 16'hFFFE, 3 channels assert together -> irq_total=16'hFFFF and remains there.
